sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arbiter_rr_pick2.sv | 12 +
 rtl/sram_arbiter.sv | 111 +++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter.
package sram_arb_pkg;
  localparam int DEF_ADDR_WIDTH    = 19;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_ACCESS_CYCLES = 4;
  localparam int CNT_WIDTH         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin winner select; last = 1 means port 1 was served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    // Only a tie consults the pointer; a lone requester always wins.
    if (req[0] && req[1]) grant = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-access SRAM controller.
// Handshake: req is held until a one-cycle ack; one access is in flight at a time.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_write_tick,
  output logic                  mem_read_tick,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output state_t                fsm_state
);
  state_t               state;
  logic [1:0]           grant;
  logic                 win;
  logic                 last;
  logic                 port;
  logic                 op_we;
  logic [CNT_WIDTH-1:0] cnt;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (grant)
  );

  assign win       = grant[1];
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last           <= 1'b1;
      port           <= 1'b0;
      op_we          <= 1'b0;
      cnt            <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_write_tick <= 1'b0;
      mem_read_tick  <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      busy           <= 1'b0;
    end else begin
      mem_write_tick <= 1'b0;
      mem_read_tick  <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            last      <= win;
            port      <= win;
            op_we     <= win ? we1 : we0;
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
            // Tick is registered here so it is high for exactly the ISSUE cycle.
            if (win ? we1 : we0) mem_write_tick <= 1'b1;
            else                 mem_read_tick  <= 1'b1;
          end
        end
        ISSUE: begin
          cnt   <= CNT_WIDTH'(ACCESS_CYCLES);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_WIDTH'(1)) begin
            state <= DONE;
            cnt   <= '0;
            if (port) ack1 <= 1'b1;
            else      ack0 <= 1'b1;
            if (!op_we) begin
              if (port) rdata1 <= mem_rdata;
              else      rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default timing instance plus an ACCESS_CYCLES=1 instance.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [18:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic        ack0, ack1, mem_write_tick, mem_read_tick, busy;
  logic [15:0] rdata0, rdata1, mem_wdata;
  logic [18:0] mem_addr;
  state_t      fsm_state;

  logic        req0_b = 0;
  logic [18:0] addr0_b = '0;
  logic [15:0] mem_rdata_b = '0;
  logic        ack0_b, ack1_b, wt_b, rt_b, busy_b;
  logic [15:0] rdata0_b, rdata1_b, mem_wdata_b;
  logic [18:0] mem_addr_b;
  state_t      fsm_state_b;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_write_tick(mem_write_tick), .mem_read_tick(mem_read_tick),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  sram_arbiter #(.ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0_b), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(addr0_b), .addr1(19'h0), .wdata0(16'h0), .wdata1(16'h0),
    .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_write_tick(wt_b), .mem_read_tick(rt_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .fsm_state(fsm_state_b)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({ack0, ack1, mem_write_tick, mem_read_tick, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, mem_write_tick, mem_read_tick, busy}); end
    tests++; if ({mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rdata0, rdata1}); end
    tests++; if (fsm_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    addr0 = 19'h00FAC; wdata0 = 16'h0078; we0 = 1'b1; req0 = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      tests++; if (mem_write_tick !== 1'(j == 1) || mem_read_tick !== 1'b0) begin
        errors++; $display("FAIL write_tick j=%0d: got w%b r%b expected w%b r0", j, mem_write_tick, mem_read_tick, 1'(j == 1)); end
      tests++; if (ack0 !== 1'(j == 6) || ack1 !== 1'b0) begin
        errors++; $display("FAIL write_ack j=%0d: got %b%b expected %b0", j, ack0, ack1, 1'(j == 6)); end
      tests++; if (busy !== 1'(j <= 6)) begin
        errors++; $display("FAIL write_busy j=%0d: got %b expected %b", j, busy, 1'(j <= 6)); end
      if (j <= 6) begin
        tests++; if (mem_addr !== 19'h00FAC || mem_wdata !== 16'h0078) begin
          errors++; $display("FAIL write_bus j=%0d: got %h/%h expected 00fac/0078", j, mem_addr, mem_wdata); end
      end
      if (j == 6) begin
        req0 = 1'b0;
        tests++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
          errors++; $display("FAIL write_rdata: got %h/%h expected 0000/0000", rdata0, rdata1); end
      end
    end
  endtask

  task automatic test_read();
    addr1 = 19'h00FAC; we1 = 1'b0; mem_rdata = 16'h0078; req1 = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      tests++; if (mem_read_tick !== 1'(j == 1) || mem_write_tick !== 1'b0) begin
        errors++; $display("FAIL read_tick j=%0d: got r%b w%b expected r%b w0", j, mem_read_tick, mem_write_tick, 1'(j == 1)); end
      tests++; if (ack1 !== 1'(j == 6) || ack0 !== 1'b0) begin
        errors++; $display("FAIL read_ack j=%0d: got %b%b expected 0%b", j, ack0, ack1, 1'(j == 6)); end
      if (j == 1) begin
        tests++; if (mem_addr !== 19'h00FAC) begin
          errors++; $display("FAIL read_addr: got %h expected 00fac", mem_addr); end
      end
      if (j == 5) begin
        tests++; if (rdata1 !== 16'h0) begin
          errors++; $display("FAIL read_early: got %h expected 0000", rdata1); end
      end
      if (j >= 6) begin
        tests++; if (rdata1 !== 16'h0078 || rdata0 !== 16'h0) begin
          errors++; $display("FAIL read_data j=%0d: got %h/%h expected 0000/0078", j, rdata0, rdata1); end
      end
      if (j == 6) req1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    addr0 = 19'h12345; wdata0 = 16'hA5A5; we0 = 1'b1; req0 = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk); #1;
      tests++; if (mem_write_tick !== 1'(j == 1 || j == 8)) begin
        errors++; $display("FAIL b2b_tick j=%0d: got %b expected %b", j, mem_write_tick, 1'(j == 1 || j == 8)); end
      tests++; if (ack0 !== 1'(j == 6 || j == 13) || ack1 !== 1'b0) begin
        errors++; $display("FAIL b2b_ack j=%0d: got %b%b expected %b0", j, ack0, ack1, 1'(j == 6 || j == 13)); end
      if (j == 13) req0 = 1'b0;
    end
    tests++; if (busy !== 1'b0 || rdata1 !== 16'h0078) begin
      errors++; $display("FAIL b2b_end: got busy %b rdata1 %h expected 0/0078", busy, rdata1); end
  endtask

  task automatic test_contention();
    int ports[$];
    int cycles[$];
    int overlap = 0;
    int exp_port[4] = '{0, 1, 0, 1};
    int exp_cyc[4] = '{6, 13, 20, 27};
    rst_n = 1'b0;
    addr0 = 19'h00001; addr1 = 19'h00002; we0 = 1'b1; we1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk); #1;
      if ((ack0 && ack1) || (mem_write_tick && mem_read_tick)) overlap++;
      if (ack0) begin ports.push_back(0); cycles.push_back(c); end
      if (ack1) begin ports.push_back(1); cycles.push_back(c); end
      if (c == 1 || c == 8) begin
        tests++; if (mem_addr !== ((c == 1) ? 19'h00001 : 19'h00002)) begin
          errors++; $display("FAIL rr_addr c=%0d: got %h", c, mem_addr); end
      end
      if (c == 27) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tests++; if (overlap != 0) begin
      errors++; $display("FAIL rr_overlap: got %0d expected 0", overlap); end
    tests++; if (ports.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d expected 4", ports.size()); end
    for (int i = 0; i < 4 && i < ports.size(); i++) begin
      tests++; if (ports[i] != exp_port[i] || cycles[i] != exp_cyc[i]) begin
        errors++; $display("FAIL rr_grant %0d: got port %0d cyc %0d expected port %0d cyc %0d",
                           i, ports[i], cycles[i], exp_port[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_drop();
    addr0 = 19'h00055; we0 = 1'b0; mem_rdata = 16'h3C3C; req0 = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      tests++; if (mem_read_tick !== 1'(j == 1) || mem_write_tick !== 1'b0) begin
        errors++; $display("FAIL drop_tick j=%0d: got r%b w%b expected r%b w0", j, mem_read_tick, mem_write_tick, 1'(j == 1)); end
      tests++; if (ack0 !== 1'(j == 6)) begin
        errors++; $display("FAIL drop_ack j=%0d: got %b expected %b", j, ack0, 1'(j == 6)); end
      if (j == 2) req0 = 1'b0;
    end
    tests++; if (rdata0 !== 16'h3C3C) begin
      errors++; $display("FAIL drop_rdata: got %h expected 3c3c", rdata0); end
  endtask

  task automatic test_reset_mid();
    addr0 = 19'h7FFFF; we0 = 1'b0; mem_rdata = 16'h1111; req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({ack0, ack1, mem_write_tick, mem_read_tick, busy} !== 5'b0 || fsm_state !== IDLE) begin
      errors++; $display("FAIL midrst_ctrl: got %b st %0d expected 00000 st 0", {ack0, ack1, mem_write_tick, mem_read_tick, busy}, fsm_state); end
    tests++; if ({mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
      errors++; $display("FAIL midrst_data: got %h expected 0", {mem_addr, mem_wdata, rdata0, rdata1}); end
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      tests++; if ({ack0, ack1, mem_write_tick, mem_read_tick, busy} !== 5'b0) begin
        errors++; $display("FAIL midrst_quiet j=%0d: got %b expected 00000", j, {ack0, ack1, mem_write_tick, mem_read_tick, busy}); end
    end
    addr0 = 19'h00ABC; wdata0 = 16'h5555; we0 = 1'b1; req0 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      tests++; if (mem_write_tick !== 1'(j == 1) || ack0 !== 1'(j == 6)) begin
        errors++; $display("FAIL midrst_next j=%0d: got t%b a%b expected t%b a%b", j, mem_write_tick, ack0, 1'(j == 1), 1'(j == 6)); end
      if (j == 6) req0 = 1'b0;
    end
    tests++; if (mem_addr !== 19'h00ABC || mem_wdata !== 16'h5555) begin
      errors++; $display("FAIL midrst_bus: got %h/%h expected 00abc/5555", mem_addr, mem_wdata); end
  endtask

  task automatic test_access1();
    addr0_b = 19'h00321; mem_rdata_b = 16'hBEEF; req0_b = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      tests++; if (rt_b !== 1'(j == 1) || wt_b !== 1'b0) begin
        errors++; $display("FAIL ac1_tick j=%0d: got r%b w%b expected r%b w0", j, rt_b, wt_b, 1'(j == 1)); end
      tests++; if (ack0_b !== 1'(j == 3) || ack1_b !== 1'b0 || busy_b !== 1'(j <= 3)) begin
        errors++; $display("FAIL ac1_ack j=%0d: got a%b busy%b expected a%b busy%b", j, ack0_b, busy_b, 1'(j == 3), 1'(j <= 3)); end
      if (j == 3) begin
        req0_b = 1'b0;
        tests++; if (rdata0_b !== 16'hBEEF || mem_addr_b !== 19'h00321) begin
          errors++; $display("FAIL ac1_data: got %h/%h expected beef/00321", rdata0_b, mem_addr_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_contention();
    test_drop();
    test_reset_mid();
    test_access1();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
